// File: rtl/registro_ciclos_param.sv
// registro_ciclos_param: load-increment / up-down counter register
// with wrap or clamp arithmetic, compare-match pulse and sticky overflow.
//
// Ports:
//   clk         rising-edge clock
//   reset       async active-low reset
//   en          cycle enable (0 = hold)
//   mode        00 hold, 01 load+STEP, 10 up, 11 down
//   data_input  load operand for mode 01
//   cmp_value   compare target for match
//   clr_flags   synchronous clear of ovf
//   data_output registered value
//   match       one-cycle pulse: updated value == cmp_value
//   ovf         sticky carry/borrow flag
module registro_ciclos_param #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_input,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_output,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH:0]   LP_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] LP_MAX  = '1;
  localparam logic [WIDTH-1:0] LP_MIN  = '0;

  logic [WIDTH:0]   w_res;
  logic [WIDTH-1:0] w_next;
  logic             w_upd;
  logic             w_evt;

  // Extra top bit of w_res is carry (add) or borrow (subtract).
  always_comb begin
    w_res  = '0;
    w_next = '0;
    w_upd  = en && (mode != 2'b00);
    unique case (mode)
      2'b01:   w_res = {1'b0, data_input} + LP_STEP;
      2'b10:   w_res = {1'b0, data_output} + LP_STEP;
      2'b11:   w_res = {1'b0, data_output} - LP_STEP;
      default: w_res = {1'b0, data_output};
    endcase
    w_evt = w_upd && w_res[WIDTH];
    if (w_evt && (SATURATE != 0)) begin
      w_next = (mode == 2'b11) ? LP_MIN : LP_MAX;
    end else begin
      w_next = w_res[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_output <= '0;
      match       <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (w_upd) begin
        data_output <= w_next;
      end
      match <= w_upd && (w_next == cmp_value);
      // A new event beats a coincident clear.
      if (w_evt) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_registro_ciclos_param.sv
// tb_registro_ciclos_param: directed checks of wrap and saturate
// instances driven in lockstep.
module tb_registro_ciclos_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] data_input = 8'h00;
  logic [7:0] cmp_value = 8'hAA;
  logic       clr_flags = 1'b0;

  logic [7:0] q_w, q_s;
  logic       m_w, m_s, o_w, o_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  registro_ciclos_param #(.WIDTH(8), .STEP(1), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .data_input(data_input), .cmp_value(cmp_value),
    .clr_flags(clr_flags), .data_output(q_w),
    .match(m_w), .ovf(o_w)
  );

  registro_ciclos_param #(.WIDTH(8), .STEP(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .data_input(data_input), .cmp_value(cmp_value),
    .clr_flags(clr_flags), .data_output(q_s),
    .match(m_s), .ovf(o_s)
  );

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] c;
    logic       cl;
    logic [7:0] qw;
    logic       mw;
    logic       ow;
    logic [7:0] qs;
    logic       ms;
    logic       os;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic [7:0] qw, input logic mw,
                         input logic ow, input logic [7:0] qs,
                         input logic ms, input logic os);
    chk({nm, ".w.q"}, 32'(q_w), 32'(qw));
    chk({nm, ".w.match"}, 32'(m_w), 32'(mw));
    chk({nm, ".w.ovf"}, 32'(o_w), 32'(ow));
    chk({nm, ".s.q"}, 32'(q_s), 32'(qs));
    chk({nm, ".s.match"}, 32'(m_s), 32'(ms));
    chk({nm, ".s.ovf"}, 32'(o_s), 32'(os));
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic e, input logic [1:0] m,
                      input logic [7:0] d, input logic [7:0] c,
                      input logic cl);
    en = e;
    mode = m;
    data_input = d;
    cmp_value = c;
    clr_flags = cl;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset away from any clock edge.
  task automatic do_reset();
    en = 1'b0;
    mode = 2'b00;
    clr_flags = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 2'b01, 8'h41, 8'hAA, 0, 8'h42, 0, 0, 8'h42, 0, 0};
    tbl[1]  = '{0, 2'b10, 8'h00, 8'hAA, 0, 8'h42, 0, 0, 8'h42, 0, 0};
    tbl[2]  = '{1, 2'b00, 8'h00, 8'hAA, 0, 8'h42, 0, 0, 8'h42, 0, 0};
    tbl[3]  = '{1, 2'b01, 8'hFE, 8'hAA, 0, 8'hFF, 0, 0, 8'hFF, 0, 0};
    tbl[4]  = '{1, 2'b10, 8'h00, 8'hAA, 0, 8'h00, 0, 1, 8'hFF, 0, 1};
    tbl[5]  = '{1, 2'b10, 8'h00, 8'hAA, 0, 8'h01, 0, 1, 8'hFF, 0, 1};
    tbl[6]  = '{1, 2'b00, 8'h00, 8'hAA, 1, 8'h01, 0, 0, 8'hFF, 0, 0};
    tbl[7]  = '{1, 2'b01, 8'h02, 8'h03, 0, 8'h03, 1, 0, 8'h03, 1, 0};
    tbl[8]  = '{1, 2'b00, 8'h00, 8'h03, 0, 8'h03, 0, 0, 8'h03, 0, 0};
    tbl[9]  = '{1, 2'b11, 8'h00, 8'h02, 0, 8'h02, 1, 0, 8'h02, 1, 0};
    tbl[10] = '{1, 2'b11, 8'hFF, 8'h00, 0, 8'h01, 0, 0, 8'h01, 0, 0};
    tbl[11] = '{1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0};
    tbl[12] = '{1, 2'b11, 8'h00, 8'h00, 0, 8'hFF, 0, 1, 8'h00, 1, 1};
    tbl[13] = '{1, 2'b11, 8'h00, 8'h00, 1, 8'hFE, 0, 0, 8'h00, 1, 1};
    tbl[14] = '{1, 2'b00, 8'h00, 8'h00, 0, 8'hFE, 0, 0, 8'h00, 0, 1};

    // Reset state before any clock edge.
    #2;
    chk_all("rst0", 8'h00, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].e, tbl[i].m, tbl[i].d, tbl[i].c, tbl[i].cl);
      chk_all($sformatf("vec%0d", i), tbl[i].qw, tbl[i].mw,
              tbl[i].ow, tbl[i].qs, tbl[i].ms, tbl[i].os);
    end

    // Up across the top: FE, FF, 00, 01.
    do_reset();
    step(1, 2'b01, 8'hFD, 8'hAA, 0);
    chk_all("up.fe", 8'hFE, 0, 0, 8'hFE, 0, 0);
    step(1, 2'b10, 8'h00, 8'hAA, 0);
    chk_all("up.1", 8'hFF, 0, 0, 8'hFF, 0, 0);
    step(1, 2'b10, 8'h00, 8'hAA, 0);
    chk_all("up.2", 8'h00, 0, 1, 8'hFF, 0, 1);
    step(1, 2'b10, 8'h00, 8'hAA, 0);
    chk_all("up.3", 8'h01, 0, 1, 8'hFF, 0, 1);

    // Down across the bottom: 01, 00, borrow.
    do_reset();
    step(1, 2'b01, 8'h00, 8'hAA, 0);
    chk_all("dn.01", 8'h01, 0, 0, 8'h01, 0, 0);
    step(1, 2'b11, 8'h00, 8'hAA, 0);
    chk_all("dn.1", 8'h00, 0, 0, 8'h00, 0, 0);
    step(1, 2'b11, 8'h00, 8'hAA, 0);
    chk_all("dn.2", 8'hFF, 0, 1, 8'h00, 0, 1);
    step(1, 2'b11, 8'h00, 8'hAA, 0);
    chk_all("dn.3", 8'hFE, 0, 1, 8'h00, 0, 1);

    // Match pulse on 05 only, then hold clears it.
    do_reset();
    step(1, 2'b01, 8'h02, 8'h05, 0);
    chk_all("mt.03", 8'h03, 0, 0, 8'h03, 0, 0);
    step(1, 2'b10, 8'h00, 8'h05, 0);
    chk_all("mt.04", 8'h04, 0, 0, 8'h04, 0, 0);
    step(1, 2'b10, 8'h00, 8'h05, 0);
    chk_all("mt.05", 8'h05, 1, 0, 8'h05, 1, 0);
    step(1, 2'b00, 8'h00, 8'h05, 0);
    chk_all("mt.hold", 8'h05, 0, 0, 8'h05, 0, 0);

    // Clear coincident with event, then clear alone.
    do_reset();
    step(1, 2'b01, 8'hFE, 8'hAA, 0);
    chk_all("cl.ff", 8'hFF, 0, 0, 8'hFF, 0, 0);
    step(1, 2'b10, 8'h00, 8'hAA, 1);
    chk_all("cl.both", 8'h00, 0, 1, 8'hFF, 0, 1);
    step(1, 2'b00, 8'h00, 8'hAA, 1);
    chk_all("cl.only", 8'h00, 0, 0, 8'hFF, 0, 0);

    // Async reset mid-count at 37.
    do_reset();
    step(1, 2'b01, 8'h35, 8'hAA, 0);
    step(1, 2'b10, 8'h00, 8'h37, 0);
    chk_all("ar.37", 8'h37, 1, 0, 8'h37, 1, 0);
    en = 1'b1;
    mode = 2'b10;
    #2;
    reset = 1'b0;
    #1;
    chk_all("ar.now", 8'h00, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk_all("ar.held", 8'h00, 0, 0, 8'h00, 0, 0);
    #2;
    reset = 1'b1;
    step(1, 2'b10, 8'h00, 8'hAA, 0);
    chk_all("ar.rel", 8'h01, 0, 0, 8'h01, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
